// File: rtl/round_reset_seq.sv
// Between-round playfield sequencer: freeze, clear, blank hold, restart.
// A win line held high for LOCK_CYCLES consecutive cycles ends the game.
module round_reset_seq #(
  parameter int CLEAR_CYCLES = 2,
  parameter int HOLD_CYCLES  = 8,
  parameter int LOCK_CYCLES  = 3,
  parameter int LOSS_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              win,
  input  logic              collision,
  output logic              field_clear,
  output logic              freeze,
  output logic              round_start,
  output logic              game_over,
  output logic [LOSS_W-1:0] loss_cnt,
  output logic [1:0]        dbg_state
);

  localparam int PHASE_MAX = (CLEAR_CYCLES > HOLD_CYCLES) ? CLEAR_CYCLES : HOLD_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);
  localparam int RUN_W     = $clog2(LOCK_CYCLES + 1);

  localparam logic [PHASE_W-1:0] CLEAR_LOAD = PHASE_W'(CLEAR_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HOLD_LOAD  = PHASE_W'(HOLD_CYCLES - 1);
  localparam logic [RUN_W-1:0]   RUN_LOCK   = RUN_W'(LOCK_CYCLES);
  localparam logic [LOSS_W-1:0]  LOSS_MAX   = '1;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CLEAR = 2'd1,
    HOLD  = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [RUN_W-1:0]   win_run_q, win_run_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               round_start_d;
  logic               lock_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= PLAY;
      phase_q     <= '0;
      win_run_q   <= '0;
      loss_q      <= '0;
      round_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      win_run_q   <= win_run_d;
      loss_q      <= loss_d;
      round_start <= round_start_d;
    end
  end

  always_comb begin
    win_run_d     = '0;
    lock_hit      = 1'b0;
    state_d       = state_q;
    phase_d       = phase_q;
    loss_d        = loss_q;
    round_start_d = 1'b0;

    // Win streak runs in every state; lock fires on the edge that samples the last win of the run.
    if (win) begin
      win_run_d = (win_run_q == RUN_LOCK) ? RUN_LOCK : win_run_q + 1'b1;
    end
    lock_hit = (win_run_d == RUN_LOCK);

    case (state_q)
      PLAY: begin
        if (win || collision) begin
          state_d = CLEAR;
          phase_d = CLEAR_LOAD;
          if (!win && (loss_q != LOSS_MAX)) begin
            loss_d = loss_q + 1'b1;
          end
        end
      end
      CLEAR: begin
        if (phase_q == '0) begin
          state_d = HOLD;
          phase_d = HOLD_LOAD;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      HOLD: begin
        if (phase_q == '0) begin
          state_d       = PLAY;
          phase_d       = '0;
          round_start_d = 1'b1;
        end else begin
          phase_d = phase_q - 1'b1;
        end
      end
      OVER: begin
        state_d = OVER;
      end
      default: begin
        state_d = PLAY;
        phase_d = '0;
      end
    endcase

    // Terminal win overrides any in-flight clear/hold timing.
    if (lock_hit) begin
      state_d       = OVER;
      phase_d       = '0;
      round_start_d = 1'b0;
    end
  end

  assign field_clear = (state_q == CLEAR) || (state_q == OVER);
  assign freeze      = (state_q != PLAY);
  assign game_over   = (state_q == OVER);
  assign loss_cnt    = loss_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_round_reset_seq.sv
// Bench for round_reset_seq: random/directed win and collision traffic,
// expected outputs from a timeline model queued and checked every cycle.
module tb_round_reset_seq;

  localparam int CLEAR_CYCLES = 2;
  localparam int HOLD_CYCLES  = 8;
  localparam int LOCK_CYCLES  = 3;
  localparam int LOSS_W       = 4;
  localparam int W            = 4 + LOSS_W;
  localparam int LOSS_SAT     = (1 << LOSS_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              win = 1'b0;
  logic              collision = 1'b0;
  logic              field_clear;
  logic              freeze;
  logic              round_start;
  logic              game_over;
  logic [LOSS_W-1:0] loss_cnt;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  round_reset_seq #(
    .CLEAR_CYCLES(CLEAR_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .LOCK_CYCLES (LOCK_CYCLES),
    .LOSS_W      (LOSS_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .win        (win),
    .collision  (collision),
    .field_clear(field_clear),
    .freeze     (freeze),
    .round_start(round_start),
    .game_over  (game_over),
    .loss_cnt   (loss_cnt),
    .dbg_state  (dbg_state)
  );

  logic [W-1:0] exp_q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Model: m_age is the position inside the clear+hold blackout (0 = playing).
  int m_age;
  int m_streak;
  int m_losses;
  bit m_over;
  bit m_rs;

  task automatic model_reset();
    m_age = 0;
    m_streak = 0;
    m_losses = 0;
    m_over = 1'b0;
    m_rs = 1'b0;
  endtask

  task automatic model_step(input bit w, input bit c);
    logic [W-1:0] e;
    int loss;
    bit clr;
    bit frz;
    m_streak = w ? m_streak + 1 : 0;
    m_rs = 1'b0;
    if (m_over) begin
      m_over = 1'b1;
    end else if (m_streak >= LOCK_CYCLES) begin
      m_over = 1'b1;
      m_age = 0;
    end else if (m_age == 0) begin
      if (w || c) begin
        m_age = 1;
        if (c && !w) m_losses++;
      end
    end else begin
      m_age++;
      if (m_age > CLEAR_CYCLES + HOLD_CYCLES) begin
        m_age = 0;
        m_rs = 1'b1;
      end
    end
    loss = (m_losses > LOSS_SAT) ? LOSS_SAT : m_losses;
    clr = m_over || (m_age >= 1 && m_age <= CLEAR_CYCLES);
    frz = m_over || (m_age >= 1);
    e = {clr, frz, m_rs, m_over, LOSS_W'(loss)};
    exp_q.push_back(e);
  endtask

  logic [W-1:0] exp_v;
  logic [W-1:0] act_v;

  always @(negedge clk) begin
    if (reset && exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {field_clear, freeze, round_start, game_over, loss_cnt};
      cyc++;
      tests_run++;
      if (act_v !== exp_v) begin
        tests_failed++;
        $display("FAIL cycle_%0d {clear,freeze,start,over,loss}: got %b want %b", cyc, act_v, exp_v);
      end
    end
  end

  task automatic check_reset(input string name);
    logic [W+1:0] got;
    got = {field_clear, freeze, round_start, game_over, loss_cnt, dbg_state};
    tests_run++;
    if (got !== '0) begin
      tests_failed++;
      $display("FAIL %s: outputs+state got %b want all zero", name, got);
    end
  endtask

  task automatic cycle(input bit w, input bit c);
    win = w;
    collision = c;
    @(posedge clk);
    model_step(w, c);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
  endtask

  task automatic apply_reset(input string name);
    #1 reset = 1'b0;
    #1 check_reset(name);
    exp_q.delete();
    model_reset();
    win = 1'b0;
    collision = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 check_reset("power_on_reset");
    @(negedge clk);
    #1 reset = 1'b1;

    // Single win pulse: 2 clear, 8 hold, then a start pulse.
    idle(3);
    cycle(1'b1, 1'b0);
    idle(12);

    // Collision held 4 cycles, then held through a resume.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1);
    idle(12);
    for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1);
    idle(12);

    // Reset in the middle of the hold phase.
    cycle(1'b0, 1'b1);
    idle(5);
    apply_reset("reset_mid_hold");
    idle(3);

    // Win and collision together: no loss counted.
    cycle(1'b1, 1'b1);
    idle(12);

    // Win held: lock into game over, then toggling win must not matter.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) cycle(i[0], i[1]);
    idle(4);
    apply_reset("reset_from_over");

    // Seventeen collision rounds: counter saturates.
    for (int i = 0; i < 17 * (CLEAR_CYCLES + HOLD_CYCLES + 1) + 2; i++) cycle(1'b0, 1'b1);
    idle(3);
    apply_reset("reset_after_saturation");

    // Randomized play with occasional held wins.
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 250; i++) begin
        if ($urandom_range(0, 149) == 0) begin
          for (int j = 0; j < int'($urandom_range(2, 4)); j++) cycle(1'b1, 1'($urandom_range(0, 1)));
        end else begin
          cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) == 0));
        end
      end
      apply_reset("reset_random_block");
    end

    idle(2);
    @(negedge clk);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL queue_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
